// File: rtl/cavlc_pkg.sv
// cavlc_pkg: definitions shared by the CAVLC encoder and the decoder-side
// coefficient rebuild block.
//   CAVLC_COEF_W / CAVLC_RUN_W : default coefficient and run widths
//   MAX_COEF                   : coefficients in a 4x4 block
//   cavlc_state_e              : rebuild FSM states
//   ZZ4x4 / zz_raster()        : zigzag scan position -> raster index
package cavlc_pkg;

  localparam int CAVLC_COEF_W = 32'd8;
  localparam int CAVLC_RUN_W  = 32'd4;
  localparam int MAX_COEF     = 32'd16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEVEL = 2'd1,
    PLACE = 2'd2,
    OUT   = 2'd3
  } cavlc_state_e;

  // Element 0 is the first entry, so ZZ4x4[scan_pos] gives the raster index.
  localparam logic [0:15][3:0] ZZ4x4 = {
    4'd0,  4'd1,  4'd4,  4'd8,
    4'd5,  4'd2,  4'd3,  4'd6,
    4'd9,  4'd12, 4'd13, 4'd10,
    4'd7,  4'd11, 4'd14, 4'd15
  };

  function automatic logic [3:0] zz_raster(input logic [3:0] scan_pos);
    return ZZ4x4[scan_pos];
  endfunction

endpackage

// File: rtl/cavlc_level_buf.sv
// cavlc_level_buf: 16-entry level register file for one 4x4 block.
//   clk, rst     : clock, asynchronous active-low reset
//   clr          : empty the buffer and rewind the write pointer
//   wr_en/wr_data: append one level at the write pointer
//   rd_idx       : random read index, rd_data is the stored level
module cavlc_level_buf
  import cavlc_pkg::*;
#(
  parameter int COEF_W = CAVLC_COEF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [COEF_W-1:0] wr_data,
  input  logic [3:0]        rd_idx,
  output logic [COEF_W-1:0] rd_data
);

  logic [MAX_COEF-1:0][COEF_W-1:0] mem_r;
  logic [3:0]                      wr_ptr_r;

  // Levels are appended in arrival order; cleared at the start of each block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_r    <= '0;
      wr_ptr_r <= 4'd0;
    end else if (clr) begin
      mem_r    <= '0;
      wr_ptr_r <= 4'd0;
    end else if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
      wr_ptr_r        <= wr_ptr_r + 4'd1;
    end
  end

  assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/cavlc_coeff_rebuild.sv
// cavlc_coeff_rebuild: rebuilds the 16 raster-order coefficients of a 4x4
// block from parsed CAVLC syntax elements (header, levels, run_before).
//   clk, rst                       : clock, asynchronous active-low reset
//   hdr_valid_i/hdr_ready_o        : header handshake
//   total_coeff_i, trailing_ones_i, total_zeros_i : header fields
//   sym_valid_i/sym_ready_o, sym_i : level or run_before symbol stream
//   coef_o                         : packed block, element r*4+c at [(r*4+c)*COEF_W +: COEF_W]
//   out_valid_o/out_ready_i        : block handshake
//   err_o                          : sticky syntax error flag
// Build option: define CAVLC_CHECK_EN to enable syntax checking and
// saturating position/zero-left arithmetic; otherwise err_o is tied low.
module cavlc_coeff_rebuild
  import cavlc_pkg::*;
#(
  parameter int COEF_W = CAVLC_COEF_W,
  parameter int RUN_W  = CAVLC_RUN_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hdr_valid_i,
  output logic                   hdr_ready_o,
  input  logic [4:0]             total_coeff_i,
  input  logic [1:0]             trailing_ones_i,
  input  logic [RUN_W-1:0]       total_zeros_i,
  input  logic                   sym_valid_i,
  output logic                   sym_ready_o,
  input  logic [COEF_W-1:0]      sym_i,
  output logic [16*COEF_W-1:0]   coef_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   err_o
);

  cavlc_state_e state_r, state_s;
  logic [4:0] tc_r, tc_s, pos_r, pos_s, zl_r, zl_s, i_r, i_s;
  logic       hdr_ready_r, sym_ready_r, out_valid_r, sym_ready_s;
  logic [MAX_COEF-1:0][COEF_W-1:0] coef_r;
  logic       hdr_fire_s, sym_fire_s, out_fire_s;
  logic       lvl_we_s, blk_clr_s, coef_we_s, last_s;
  logic [COEF_W-1:0] lvl_rd_s;
  logic [4:0] run_s, tz_s;
  logic [4:0] pos_hdr_s, pos_run_s, zl_run_s, pos_imp_s;

  // Readies are registered, so a transfer is decided purely by flop state.
  assign hdr_fire_s = hdr_valid_i && hdr_ready_r;
  assign sym_fire_s = sym_valid_i && sym_ready_r;
  assign out_fire_s = out_valid_r && out_ready_i;
  assign run_s      = 5'(sym_i[RUN_W-1:0]);
  assign tz_s       = 5'(total_zeros_i);
  assign last_s     = (i_r == tc_r - 5'd1);

  cavlc_level_buf #(.COEF_W(COEF_W)) u_level_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (blk_clr_s),
    .wr_en   (lvl_we_s),
    .wr_data (sym_i),
    .rd_idx  (i_r[3:0]),
    .rd_data (lvl_rd_s)
  );

`ifdef CAVLC_CHECK_EN
  logic [1:0] t1_r;
  logic       err_r, err_s, lvl_bad_s;
  logic [5:0] hdr_sum_s;

  assign hdr_sum_s = 6'(total_coeff_i) + 6'(tz_s);
  // A level among the first T1 must be exactly +1 or -1.
  assign lvl_bad_s = (i_r < {3'd0, t1_r}) &&
                     (sym_i != COEF_W'(1'b1)) && (sym_i != {COEF_W{1'b1}});

  // Saturating updates so a malformed block still runs to completion.
  always_comb begin
    pos_hdr_s = (hdr_sum_s > 6'd16) ? 5'd15 : 5'(hdr_sum_s - 6'd1);
    pos_run_s = ((run_s + 5'd1) > pos_r) ? 5'd0 : (pos_r - run_s - 5'd1);
    zl_run_s  = (run_s > zl_r) ? 5'd0 : (zl_r - run_s);
    pos_imp_s = (pos_r == 5'd0) ? 5'd0 : (pos_r - 5'd1);
  end

  // Error flag: reloaded from the header checks on accept, then only set.
  always_comb begin
    err_s = err_r;
    if (hdr_fire_s) begin
      err_s = (hdr_sum_s > 6'd16) || (total_coeff_i > 5'd16) ||
              ({3'd0, trailing_ones_i} > total_coeff_i);
    end else if ((state_r == LEVEL) && sym_fire_s && lvl_bad_s) begin
      err_s = 1'b1;
    end else if ((state_r == PLACE) && sym_fire_s &&
                 ((run_s > zl_r) || ((run_s + 5'd1) > pos_r))) begin
      err_s = 1'b1;
    end else if ((state_r == PLACE) && !last_s && (zl_r == 5'd0) && (pos_r == 5'd0)) begin
      err_s = 1'b1;
    end else begin
      err_s = err_r;
    end
  end

  // Trailing-ones count and sticky error register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t1_r  <= 2'd0;
      err_r <= 1'b0;
    end else begin
      if (hdr_fire_s) begin
        t1_r <= trailing_ones_i;
      end
      err_r <= err_s;
    end
  end

  assign err_o = err_r;
`else
  logic unused_t1_s;
  assign unused_t1_s = ^trailing_ones_i;

  // Plain wrapping updates; well-formed syntax never underflows.
  always_comb begin
    pos_hdr_s = total_coeff_i + tz_s - 5'd1;
    pos_run_s = pos_r - run_s - 5'd1;
    zl_run_s  = zl_r - run_s;
    pos_imp_s = pos_r - 5'd1;
  end

  assign err_o = 1'b0;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_s   = state_r;
    tc_s      = tc_r;
    pos_s     = pos_r;
    zl_s      = zl_r;
    i_s       = i_r;
    lvl_we_s  = 1'b0;
    blk_clr_s = 1'b0;
    coef_we_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (hdr_fire_s) begin
          tc_s      = total_coeff_i;
          pos_s     = pos_hdr_s;
          zl_s      = tz_s;
          i_s       = 5'd0;
          blk_clr_s = 1'b1;
          if (total_coeff_i == 5'd0) begin
            state_s = OUT;
          end else begin
            state_s = LEVEL;
          end
        end else begin
          state_s = IDLE;
        end
      end
      LEVEL: begin
        if (sym_fire_s) begin
          lvl_we_s = 1'b1;
          if (last_s) begin
            i_s     = 5'd0;
            state_s = PLACE;
          end else begin
            i_s = i_r + 5'd1;
          end
        end else begin
          state_s = LEVEL;
        end
      end
      PLACE: begin
        // The last coefficient absorbs whatever zeros remain, no run needed.
        if (last_s) begin
          coef_we_s = 1'b1;
          state_s   = OUT;
        end else if (zl_r == 5'd0) begin
          coef_we_s = 1'b1;
          pos_s     = pos_imp_s;
          i_s       = i_r + 5'd1;
        end else if (sym_fire_s) begin
          coef_we_s = 1'b1;
          pos_s     = pos_run_s;
          zl_s      = zl_run_s;
          i_s       = i_r + 5'd1;
        end else begin
          state_s = PLACE;
        end
      end
      OUT: begin
        if (out_fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Symbol ready for the coming cycle: levels always, runs only while zeros remain.
  assign sym_ready_s = (state_s == LEVEL) ||
                       ((state_s == PLACE) && (i_s != tc_s - 5'd1) && (zl_s != 5'd0));

  // State, counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      tc_r        <= 5'd0;
      pos_r       <= 5'd0;
      zl_r        <= 5'd0;
      i_r         <= 5'd0;
      hdr_ready_r <= 1'b0;
      sym_ready_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      tc_r        <= tc_s;
      pos_r       <= pos_s;
      zl_r        <= zl_s;
      i_r         <= i_s;
      hdr_ready_r <= (state_s == IDLE);
      sym_ready_r <= sym_ready_s;
      out_valid_r <= (state_s == OUT);
    end
  end

  // Coefficient block: cleared per header, filled through the inverse zigzag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coef_r <= '0;
    end else if (blk_clr_s) begin
      coef_r <= '0;
    end else if (coef_we_s) begin
      coef_r[zz_raster(pos_r[3:0])] <= lvl_rd_s;
    end
  end

  assign hdr_ready_o = hdr_ready_r;
  assign sym_ready_o = sym_ready_r;
  assign out_valid_o = out_valid_r;
  assign coef_o      = coef_r;

endmodule

// File: tb/tb_cavlc_coeff_rebuild.sv
module tb_cavlc_coeff_rebuild;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         hdr_valid_i, hdr_ready_o;
  logic [4:0]   total_coeff_i;
  logic [1:0]   trailing_ones_i;
  logic [3:0]   total_zeros_i;
  logic         sym_valid_i, sym_ready_o;
  logic [7:0]   sym_i;
  logic [127:0] coef_o;
  logic         out_valid_o, out_ready_i, err_o;

  int total = 0;
  int bad   = 0;
  int zz_tab [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  int blk_lvl [$];
  int blk_run [$];

  cavlc_coeff_rebuild dut (
    .clk             (clk),
    .rst             (rst),
    .hdr_valid_i     (hdr_valid_i),
    .hdr_ready_o     (hdr_ready_o),
    .total_coeff_i   (total_coeff_i),
    .trailing_ones_i (trailing_ones_i),
    .total_zeros_i   (total_zeros_i),
    .sym_valid_i     (sym_valid_i),
    .sym_ready_o     (sym_ready_o),
    .sym_i           (sym_i),
    .coef_o          (coef_o),
    .out_valid_o     (out_valid_o),
    .out_ready_i     (out_ready_i),
    .err_o           (err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference: fill scan positions from the top down, then inverse-zigzag.
  function automatic logic [127:0] model_block(input int tc, input int tz);
    int scan [16];
    int p, zl, r, ri;
    logic [127:0] v;
    for (int k = 0; k < 16; k++) scan[k] = 0;
    p = tc + tz - 1;
    zl = tz;
    ri = 0;
    for (int k = 0; k < tc; k++) begin
      scan[p] = blk_lvl[k];
      if (k < tc - 1) begin
        r = 0;
        if (zl > 0) begin
          r = blk_run[ri];
          ri++;
        end
        p = p - 1 - r;
        zl = zl - r;
      end
    end
    v = '0;
    for (int s = 0; s < 16; s++) v[zz_tab[s]*W +: W] = W'(scan[s]);
    return v;
  endfunction

  task automatic gen_block(output int tc, output int t1, output int tz);
    int zl, r, v;
    tc = $urandom_range(0, 16);
    tz = (tc == 0 || tc == 16) ? 0 : $urandom_range(0, 16 - tc);
    t1 = (tc < 3) ? $urandom_range(0, tc) : $urandom_range(0, 3);
    blk_lvl = {};
    blk_run = {};
    for (int k = 0; k < tc; k++) begin
      v = (k < t1) ? 1 : $urandom_range(1, 100);
      if ($urandom_range(0, 1) == 1) v = -v;
      blk_lvl.push_back(v);
    end
    zl = tz;
    for (int k = 0; k < tc - 1; k++) begin
      if (zl > 0) begin
        r = $urandom_range(0, zl);
        blk_run.push_back(r);
        zl = zl - r;
      end
    end
  endtask

  task automatic run_block(input int tc, input int t1, input int tz, input int stall_pct,
                           input int hold, input logic exp_err, input logic [127:0] exp_vec,
                           input int abort_after);
    logic [7:0] q [$];
    logic [3:0] hi;
    int  c, used;
    bit  extra, fire;
    q = {};
    foreach (blk_lvl[k]) q.push_back(W'(blk_lvl[k]));
    foreach (blk_run[k]) begin
      hi = 4'($urandom_range(0, 15));
      q.push_back({hi, 4'(blk_run[k])});
    end
    c = 0;
    while (!hdr_ready_o && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    if (!hdr_ready_o) begin
      check_eq("hdr_timeout", 1'b0, 1'b1);
      return;
    end
    hdr_valid_i     = 1'b1;
    total_coeff_i   = 5'(tc);
    trailing_ones_i = 2'(t1);
    total_zeros_i   = 4'(tz);
    @(posedge clk); #1;
    hdr_valid_i = 1'b0;
    check_eq("err_clr", err_o, 1'b0);
    c = 1;
    used = 0;
    extra = 1'b0;
    while (c < 400) begin
      if (out_valid_o) break;
      if (sym_ready_o && q.size() == 0) extra = 1'b1;
      if (q.size() > 0 && $urandom_range(0, 99) >= stall_pct) begin
        sym_valid_i = 1'b1;
        sym_i = q[0];
      end else begin
        sym_valid_i = (q.size() == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        sym_i = 8'($urandom_range(0, 255));
      end
      // Stray header traffic while busy must be ignored.
      hdr_valid_i   = ($urandom_range(0, 3) == 0);
      total_coeff_i = 5'($urandom_range(0, 16));
      fire = sym_valid_i && sym_ready_o;
      @(posedge clk); #1;
      if (fire) begin
        void'(q.pop_front());
        used++;
      end
      c++;
      if (abort_after > 0 && used == abort_after) begin
        sym_valid_i = 1'b0;
        hdr_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("rst_coef", coef_o, 128'd0);
        check_eq("rst_ctl", {hdr_ready_o, sym_ready_o, out_valid_o, err_o}, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        return;
      end
    end
    sym_valid_i = 1'b0;
    hdr_valid_i = 1'b0;
    check_eq("out_timeout", out_valid_o, 1'b1);
    check_eq("leftover_syms", q.size(), 0);
    check_eq("extra_sym_req", extra, 1'b0);
    if (stall_pct == 0) check_eq("latency", c, 1 + 2 * tc);
    check_eq("coef", coef_o, exp_vec);
    check_eq("err", err_o, exp_err);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", out_valid_o, 1'b1);
      check_eq("hold_coef", coef_o, exp_vec);
    end
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    check_eq("out_release", out_valid_o, 1'b0);
    check_eq("hdr_ready_back", hdr_ready_o, 1'b1);
  endtask

  initial begin
    int encv [16] = '{-12, 7, 0, 1, 7, 1, -3, 0, 0, -5, -3, 0, 0, -2, 2, 1};
    int enc_lvl [11] = '{1, 2, -3, -2, -5, -3, 1, 1, 7, 7, -12};
    int enc_run [8] = '{0, 2, 0, 1, 0, 0, 1, 1};
    logic [127:0] enc_vec, full_vec, v;
    int tc, t1, tz;

    rst = 1'b0;
    hdr_valid_i = 1'b0;
    total_coeff_i = 5'd0;
    trailing_ones_i = 2'd0;
    total_zeros_i = 4'd0;
    sym_valid_i = 1'b0;
    sym_i = 8'd0;
    out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ctl", {hdr_ready_o, sym_ready_o, out_valid_o, err_o}, 4'd0);
    check_eq("reset_coef", coef_o, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    enc_vec = '0;
    for (int k = 0; k < 16; k++) enc_vec[k*W +: W] = W'(encv[k]);
    full_vec = '0;
    for (int p = 0; p < 16; p++) full_vec[zz_tab[p]*W +: W] = W'(p + 1);

    // Encoder vector, no stalls.
    blk_lvl = {};
    blk_run = {};
    foreach (enc_lvl[k]) blk_lvl.push_back(enc_lvl[k]);
    foreach (enc_run[k]) blk_run.push_back(enc_run[k]);
    run_block(11, 1, 5, 0, 0, 1'b0, enc_vec, 0);

    // Empty block.
    blk_lvl = {};
    blk_run = {};
    run_block(0, 0, 0, 0, 0, 1'b0, 128'd0, 0);

    // Full block, levels 16..1.
    blk_lvl = {};
    blk_run = {};
    for (int k = 0; k < 16; k++) blk_lvl.push_back(16 - k);
    run_block(16, 0, 0, 0, 0, 1'b0, full_vec, 0);

    // Encoder vector with symbol stalls and output backpressure.
    blk_lvl = {};
    blk_run = {};
    foreach (enc_lvl[k]) blk_lvl.push_back(enc_lvl[k]);
    foreach (enc_run[k]) blk_run.push_back(enc_run[k]);
    run_block(11, 1, 5, 40, 5, 1'b0, enc_vec, 0);

    // Reset during placement (11 levels + 4 runs consumed -> i=4), then a full block.
    run_block(11, 1, 5, 0, 0, 1'b0, enc_vec, 15);
    blk_lvl = {};
    blk_run = {};
    for (int k = 0; k < 16; k++) blk_lvl.push_back(16 - k);
    run_block(16, 0, 0, 0, 0, 1'b0, full_vec, 0);

`ifdef CAVLC_CHECK_EN
    // run=5 exceeds zeros_left=3: flagged, positions saturate, block completes.
    blk_lvl = {};
    blk_run = {};
    blk_lvl.push_back(1);
    blk_lvl.push_back(4);
    blk_run.push_back(5);
    v = '0;
    v[5*W +: W] = 8'd1;
    v[0*W +: W] = 8'd4;
    run_block(2, 0, 3, 0, 0, 1'b1, v, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      gen_block(tc, t1, tz);
      v = model_block(tc, tz);
      run_block(tc, t1, tz, ($urandom_range(0, 1) == 1) ? 30 : 0,
                $urandom_range(0, 3), 1'b0, v, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cavlc_coeff_rebuild.md
Name: cavlc_coeff_rebuild

Overview:
- Decoder-side counterpart of the H.264 CAVLC encoder top.
- Accepts parsed CAVLC syntax elements for one 4x4 block: a header (TotalCoeff, TrailingOnes, total_zeros), then level values, then run_before values.
- Rebuilds the 16 signed coefficients in raster order by inverse zigzag scan.
- Sits between the bitstream parser and the inverse quantiser in the decode and reconstruction loopback path.

Parameters:
- COEF_W, 8: signed coefficient width; matches the encoder scale inputs.
- RUN_W, 4: width of run_before and total_zeros.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- hdr_valid_i  in  1  header valid.
- hdr_ready_o  out  1  header accept.
- total_coeff_i  in  5  TotalCoeff, 0..16.
- trailing_ones_i  in  2  TrailingOnes, 0..3.
- total_zeros_i  in  RUN_W  total_zeros, 0..15.
- sym_valid_i  in  1  symbol valid.
- sym_ready_o  out  1  symbol accept.
- sym_i  in  COEF_W  signed level, or unsigned run_before in the low RUN_W bits.
- coef_o  out  16*COEF_W  packed block; element r*4+c is at bits [(r*4+c)*COEF_W +: COEF_W].
- out_valid_o  out  1  block valid.
- out_ready_i  in  1  block accept.
- err_o  out  1  syntax error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - All outputs 0, including coef_o, out_valid_o and err_o.
  - Level buffer and counters cleared.
  - Reset mid-block abandons the block; nothing partial is ever presented.
- Handshakes: a transfer occurs when valid&&ready on the rising edge. Only one channel's ready is high in any cycle.
- IDLE:
  - hdr_ready_o=1.
  - On accept: latch TC, T1 and TZ; clear the coefficient buffer; set pos=TC+TZ-1, zl=TZ, i=0.
  - Next state is OUT if TC==0 (block all zero), else LEVEL.
- LEVEL:
  - sym_ready_o=1.
  - Each accepted sym_i is stored in lvl[i], then i++.
  - Levels arrive highest frequency first.
  - On the accept with i==TC-1: go to PLACE with i=0.
- PLACE, one coefficient per advance:
  - Write lvl[i] to the raster index zz[pos], where zz = {0,1,4,8,5,2,3,6,9,12,13,10,7,11,14,15}.
  - If i==TC-1: write, then go to OUT. No symbol is consumed.
  - Else if zl==0: sym_ready_o=0; write; pos-=1; i++. The run is implicitly 0 and this takes 1 cycle.
  - Else: sym_ready_o=1 and wait for a symbol. On accept: write; pos-=1+run; zl-=run; i++.
- OUT:
  - out_valid_o=1; coef_o is held stable until out_ready_i.
  - On accept go to IDLE; hdr_ready_o becomes 1 in the next cycle.
- Latency: 1 (header) + TC (levels) + TC (place, plus any valid stalls) cycles to out_valid_o.
- Width and arithmetic rules:
  - pos and zl are 5-bit unsigned.
  - Levels are stored sign-intact.
  - run is sym_i[RUN_W-1:0] zero-extended.
- Boundary conditions:
  - TC=16 forces TZ=0.
  - No run is consumed for the last coefficient; it receives the remaining zl implicitly.
  - Valid asserted on a channel whose ready is low is ignored; no buffering.

Optional Feature:
- Macro: CAVLC_CHECK_EN.
- When defined, err_o is a sticky flag, cleared on the next header accept. It is set when any of these occur:
  - TC+TZ>16, or TC>16.
  - T1>TC.
  - One of the first T1 levels has magnitude ≠1.
  - run>zl.
  - pos underflows.
- On error, the block still completes with pos and zl saturated at 0, so the handshake never deadlocks.
- When undefined, err_o is tied to 0 and the check logic is absent.

Decomposition:
- Package cavlc_pkg holds:
  - the zigzag LUT constant ZZ4x4;
  - the state enum (IDLE, LEVEL, PLACE, OUT);
  - COEF_W and RUN_W defaults;
  - the max-coefficient constant 16.
  The encoder reuses this package.
- One sub-module, cavlc_level_buf: a 16-entry level register file with a write pointer and random read. The FSM stays in the top.

Test Plan:
- Encoder vector. Header TC=11, T1=1, TZ=5. Levels 1,2,-3,-2,-5,-3,1,1,7,7,-12. Runs 0,2,0,1,0,0,1,1 (8 symbols; the last two are implicit). Required coef_o rows: {-12,7,0,1}, {7,1,-3,0}, {0,-5,-3,0}, {0,-2,2,1}. out_valid_o rises 23 cycles after header accept.
- Empty block. TC=0, TZ=0. Required: out_valid_o one cycle after the header; all coef 0; sym_ready_o never high.
- Full block. TC=16, TZ=0, levels 16..1. Required: no run symbols consumed; scan position p holds 16-(15-p), placed through zz.
- Backpressure and stalls. Same stimulus as the encoder vector, with sym_valid_i toggled 0/1 randomly and out_ready_i held low for 5 cycles. Required: identical coef_o; coef_o stable while out_valid_o=1 and out_ready_i=0.
- Reset mid-block. Drive rst=0 during PLACE (i=4). Required: all outputs 0 immediately. A subsequent full block decodes correctly.
- Error check (CAVLC_CHECK_EN). Header TC=2, TZ=3, level0=1, level1=4, run=5. Required: err_o=1, block is still output, and err_o clears on the next header.
